// File: rtl/cpu_regtemp_bank.sv
// Temporary register bank for the 8008 datapath: per-channel load/inc/dec with carry,
// bus-gated and raw read ports, and a two-beat sequencer that fills an even/odd channel pair.
module cpu_regtemp_bank #(
    parameter int DW  = 8,
    parameter int NCH = 2,
    parameter int CW  = 1
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              CLR_I,
    input  logic [1:0]        OP_I,
    input  logic [CW-1:0]     WSEL_I,
    input  logic              RD_I,
    input  logic [CW-1:0]     RSEL_I,
    input  logic              PAIR_I,
    input  logic [CW-1:0]     PSEL_I,
    input  logic              STB_I,
    input  logic [DW-1:0]     DAT_I,
    output logic [DW-1:0]     DAT_O,
    output logic [DW*NCH-1:0] DAT_RAW_O,
    output logic              Z_O,
    output logic              CY_O,
    output logic              BUSY_O,
    output logic              DONE_O
);

    // Handshake: PAIR_I is taken only in IDLE; STB_I completes the pair only in HI.
    // There is no back-pressure; DONE_O pulses once, one cycle after completion.

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HI   = 1'b1
    } state_t;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_INC  = 2'b10;
    localparam logic [1:0] OP_DEC  = 2'b11;

    localparam logic [CW:0]   NCH_W = (CW+1)'(NCH);
    localparam logic [CW-1:0] ONE_W = CW'(1);

    state_t          state_q, state_d;
    logic [CW-1:0]   base_q, base_d;
    logic            done_q, done_d;
    logic            cy_q, cy_d;
    logic [DW-1:0]   ch_q [NCH];
    logic [DW-1:0]   ch_d [NCH];

    logic            seq_fire;
    logic [CW-1:0]   seq_idx;
    logic            seq_we;
    logic            wsel_ok;
    logic [DW-1:0]   wsel_val;
    logic            op_drop;
    logic [DW-1:0]   rd_val;

    // Sequencer next state and the channel it wants to write this cycle.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        done_d   = 1'b0;
        seq_fire = 1'b0;
        seq_idx  = '0;
        case (state_q)
            S_IDLE: begin
                if (PAIR_I) begin
                    seq_fire = 1'b1;
                    seq_idx  = PSEL_I & ~ONE_W;
                    base_d   = PSEL_I & ~ONE_W;
                    state_d  = S_HI;
                end
            end
            S_HI: begin
                if (STB_I) begin
                    seq_fire = 1'b1;
                    seq_idx  = base_q | ONE_W;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // An out-of-range base still walks the FSM but never touches a channel.
    assign seq_we  = seq_fire && ({1'b0, seq_idx} < NCH_W);
    assign wsel_ok = ({1'b0, WSEL_I} < NCH_W);
    assign op_drop = seq_we && (seq_idx == WSEL_I);

    always_comb begin
        wsel_val = '0;
        rd_val   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (WSEL_I == CW'(i)) wsel_val = ch_q[i];
            if (RSEL_I == CW'(i)) rd_val   = ch_q[i];
        end
    end

    // Channel update: sequencer write overrides OP_I on the same channel.
    always_comb begin
        cy_d = cy_q;
        for (int i = 0; i < NCH; i++) begin
            ch_d[i] = ch_q[i];
            if (seq_we && (seq_idx == CW'(i))) begin
                ch_d[i] = DAT_I;
            end else if (WSEL_I == CW'(i)) begin
                case (OP_I)
                    OP_LOAD: ch_d[i] = DAT_I;
                    OP_INC:  ch_d[i] = ch_q[i] + DW'(1);
                    OP_DEC:  ch_d[i] = ch_q[i] - DW'(1);
                    default: ch_d[i] = ch_q[i];
                endcase
            end
        end
        if (wsel_ok && !op_drop) begin
            case (OP_I)
                OP_INC:  cy_d = (wsel_val == {DW{1'b1}});
                OP_DEC:  cy_d = (wsel_val == '0);
                OP_NONE,
                OP_LOAD: cy_d = cy_q;
                default: cy_d = cy_q;
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I || CLR_I) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            done_q  <= 1'b0;
            cy_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) ch_q[i] <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            done_q  <= done_d;
            cy_q    <= cy_d;
            for (int i = 0; i < NCH; i++) ch_q[i] <= ch_d[i];
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_raw
        assign DAT_RAW_O[g*DW +: DW] = ch_q[g];
    end

    assign DAT_O  = RD_I ? rd_val : '0;
    assign Z_O    = (rd_val == '0);
    assign CY_O   = cy_q;
    assign BUSY_O = (state_q == S_HI);
    assign DONE_O = done_q;

endmodule

// File: tb/tb_cpu_regtemp_bank.sv
// Directed bench for cpu_regtemp_bank: reset, load/read, inc/dec wrap, pair load,
// abort by clear, and sequencer/OP conflicts, each with hand-computed expectations.
module tb_cpu_regtemp_bank;

    logic        clk = 1'b0;
    logic        rst, clr, rd, pair, stb;
    logic [1:0]  op;
    logic [0:0]  wsel, rsel, psel;
    logic [7:0]  dat_i;
    logic [7:0]  dat_o;
    logic [15:0] dat_raw;
    logic        z, cy, busy, done;

    int n_total = 0;
    int n_pass  = 0;

    cpu_regtemp_bank #(.DW(8), .NCH(2), .CW(1)) dut (
        .CLK_I(clk), .RST_I(rst), .CLR_I(clr), .OP_I(op), .WSEL_I(wsel),
        .RD_I(rd), .RSEL_I(rsel), .PAIR_I(pair), .PSEL_I(psel), .STB_I(stb),
        .DAT_I(dat_i), .DAT_O(dat_o), .DAT_RAW_O(dat_raw), .Z_O(z),
        .CY_O(cy), .BUSY_O(busy), .DONE_O(done)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; op = 2'b00; wsel = 0; rd = 0; rsel = 0;
        pair = 0; psel = 0; stb = 0; dat_i = 8'h00;
    endtask

    task automatic test_reset();
        op = 2'b01; wsel = 0; dat_i = 8'($urandom_range(1, 255)); tick();
        wsel = 1; dat_i = 8'($urandom_range(1, 255)); tick();
        op = 2'b11; wsel = 0; dat_i = 8'h00; tick();
        op = 2'b00;
        rst = 1; tick(); rst = 0;
        rd = 1; rsel = 0; #1;
        n_total++; if (dat_raw !== 16'h0000) $display("FAIL reset_raw got=%h exp=%h", dat_raw, 16'h0000); else n_pass++;
        n_total++; if (cy !== 1'b0) $display("FAIL reset_cy got=%b exp=0", cy); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
        n_total++; if (z !== 1'b1) $display("FAIL reset_z got=%b exp=1", z); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
        n_total++; if (dat_o !== 8'h00) $display("FAIL reset_dat_o got=%h exp=00", dat_o); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_load_read();
        op = 2'b01; wsel = 1; dat_i = 8'hA5; tick();
        op = 2'b00; rsel = 1; rd = 0; #1;
        n_total++; if (dat_o !== 8'h00) $display("FAIL load_gated got=%h exp=00", dat_o); else n_pass++;
        n_total++; if (z !== 1'b0) $display("FAIL load_z got=%b exp=0", z); else n_pass++;
        rd = 1; #1;
        n_total++; if (dat_o !== 8'hA5) $display("FAIL load_read got=%h exp=a5", dat_o); else n_pass++;
        n_total++; if (dat_raw !== 16'hA500) $display("FAIL load_raw got=%h exp=a500", dat_raw); else n_pass++;
        rsel = 0; #1;
        n_total++; if (z !== 1'b1) $display("FAIL load_z_ch0 got=%b exp=1", z); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_wrap();
        op = 2'b01; wsel = 0; dat_i = 8'hFF; tick();
        op = 2'b10; tick(); op = 2'b00;
        n_total++; if (dat_raw[7:0] !== 8'h00) $display("FAIL wrap_inc got=%h exp=00", dat_raw[7:0]); else n_pass++;
        n_total++; if (cy !== 1'b1) $display("FAIL wrap_inc_cy got=%b exp=1", cy); else n_pass++;
        op = 2'b01; wsel = 1; dat_i = 8'h40; tick(); op = 2'b00;
        n_total++; if (cy !== 1'b1) $display("FAIL load_holds_cy got=%b exp=1", cy); else n_pass++;
        op = 2'b11; wsel = 0; tick(); op = 2'b00;
        n_total++; if (dat_raw[7:0] !== 8'hFF) $display("FAIL wrap_dec got=%h exp=ff", dat_raw[7:0]); else n_pass++;
        n_total++; if (cy !== 1'b1) $display("FAIL wrap_dec_cy got=%b exp=1", cy); else n_pass++;
        op = 2'b11; tick(); op = 2'b00;
        n_total++; if (dat_raw !== 16'h40FE) $display("FAIL dec_plain got=%h exp=40fe", dat_raw); else n_pass++;
        n_total++; if (cy !== 1'b0) $display("FAIL dec_plain_cy got=%b exp=0", cy); else n_pass++;
        op = 2'b10; wsel = 1; tick(); op = 2'b00;
        n_total++; if (dat_raw[15:8] !== 8'h41 || cy !== 1'b0) $display("FAIL inc_ch1 got=%h/%b exp=41/0", dat_raw[15:8], cy); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_pair();
        pair = 1; psel = 1; dat_i = 8'h34; tick(); pair = 0;
        n_total++; if (dat_raw[7:0] !== 8'h34) $display("FAIL pair_first got=%h exp=34", dat_raw[7:0]); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin pair = 1; psel = 0; dat_i = 8'h99; end
            tick(); pair = 0;
            n_total++; if (busy !== 1'b1 || done !== 1'b0) $display("FAIL pair_wait%0d busy=%b done=%b exp=1/0", i, busy, done); else n_pass++;
        end
        n_total++; if (dat_raw !== 16'h4134) $display("FAIL pair_in_hi_ignored got=%h exp=4134", dat_raw); else n_pass++;
        stb = 1; dat_i = 8'h12; tick(); stb = 0;
        n_total++; if (dat_raw !== 16'h1234) $display("FAIL pair_done_raw got=%h exp=1234", dat_raw); else n_pass++;
        n_total++; if (busy !== 1'b0 || done !== 1'b1) $display("FAIL pair_done busy=%b done=%b exp=0/1", busy, done); else n_pass++;
        tick();
        n_total++; if (done !== 1'b0) $display("FAIL pair_done_pulse got=%b exp=0", done); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_abort();
        pair = 1; psel = 0; dat_i = 8'h34; tick(); pair = 0;
        n_total++; if (busy !== 1'b1 || dat_raw[7:0] !== 8'h34) $display("FAIL abort_start busy=%b ch0=%h exp=1/34", busy, dat_raw[7:0]); else n_pass++;
        clr = 1; tick(); clr = 0;
        n_total++; if (dat_raw !== 16'h0000 || busy !== 1'b0) $display("FAIL abort_clr raw=%h busy=%b exp=0000/0", dat_raw, busy); else n_pass++;
        n_total++; if (done !== 1'b0) $display("FAIL abort_done0 got=%b exp=0", done); else n_pass++;
        stb = 1; dat_i = 8'h56; tick(); stb = 0;
        n_total++; if (done !== 1'b0 || dat_raw !== 16'h0000) $display("FAIL abort_stb_ignored done=%b raw=%h exp=0/0000", done, dat_raw); else n_pass++;
        idle_inputs();
    endtask

    task automatic test_conflict();
        op = 2'b01; wsel = 1; dat_i = 8'hFF; tick();
        op = 2'b10; tick(); op = 2'b00;
        n_total++; if (cy !== 1'b1 || dat_raw[15:8] !== 8'h00) $display("FAIL conf_setup cy=%b ch1=%h exp=1/00", cy, dat_raw[15:8]); else n_pass++;
        pair = 1; psel = 0; dat_i = 8'h10; tick(); pair = 0;
        stb = 1; dat_i = 8'h77; op = 2'b10; wsel = 1; tick(); stb = 0; op = 2'b00;
        n_total++; if (dat_raw !== 16'h7710) $display("FAIL conf_same_raw got=%h exp=7710", dat_raw); else n_pass++;
        n_total++; if (cy !== 1'b1) $display("FAIL conf_same_cy got=%b exp=1", cy); else n_pass++;
        pair = 1; psel = 0; dat_i = 8'h20; tick(); pair = 0;
        stb = 1; dat_i = 8'h55; op = 2'b11; wsel = 0; tick(); stb = 0; op = 2'b00;
        n_total++; if (dat_raw !== 16'h551F) $display("FAIL conf_diff_raw got=%h exp=551f", dat_raw); else n_pass++;
        n_total++; if (cy !== 1'b0 || done !== 1'b1) $display("FAIL conf_diff cy=%b done=%b exp=0/1", cy, done); else n_pass++;
        pair = 1; psel = 0; dat_i = 8'h66; op = 2'b01; wsel = 1; tick(); pair = 0; op = 2'b00;
        n_total++; if (dat_raw !== 16'h6666 || busy !== 1'b1) $display("FAIL conf_first_beat raw=%h busy=%b exp=6666/1", dat_raw, busy); else n_pass++;
        stb = 1; dat_i = 8'h01; tick(); stb = 0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
        test_reset();
        test_load_read();
        test_wrap();
        test_pair();
        test_abort();
        test_conflict();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
